layer1_weight_buffer: RTL and testbench
=======================================

# layer1_weight_buffer

Row-organised weight store serving the `layer1` broadcast array. The host fills the buffer through a narrow valid/ready load stream. Once filled, it answers the layer's per-step row read (`weight_load` plus a row address) with one full `DATA_WIDTH*OUTPUT_NODES` weight row, one cycle later. It sits between the host/DMA weight path and the `weights` input of `layer1`.

## Interface
- `DATA_WIDTH`, 8: bits per weight.
- `INPUT_NODES`, 24: number of rows (one per input step).
- `OUTPUT_NODES`, 128: weights per row (one per PE).
- `LOAD_WIDTH`, 64: load beat width; must divide `DATA_WIDTH*OUTPUT_NODES`.
- `ADDR_WIDTH`, 5: row address width; requires `2**ADDR_WIDTH >= INPUT_NODES`.
- `clk` in, 1: single clock, rising edge.
- `reset` in, 1: synchronous, active-high.
- `start_load` in, 1: pulse that begins a full buffer refill.
- `load_valid` in, 1: load beat valid.
- `load_ready` out, 1: buffer accepts a beat.
- `load_data` in, `LOAD_WIDTH`: load beat payload.
- `buf_ready` out, 1: buffer fully loaded and readable.
- `weight_load` in, 1: row read request.
- `weight_address1` in, `ADDR_WIDTH`: row index to read.
- `weights` out, `DATA_WIDTH*OUTPUT_NODES`: registered row data.
- `weights_valid` out, 1: one-cycle strobe, `weights` updated.
- `addr_err` out, 1: sticky out-of-range flag (only when the macro is defined).

## Operation
- Derived constants:
  - BEATS_PER_ROW = `DATA_WIDTH*OUTPUT_NODES/LOAD_WIDTH` (16 at defaults).
  - TOTAL_BEATS = `INPUT_NODES*BEATS_PER_ROW` (384).
- FSM states are IDLE, FILL and LOADED.
  - IDLE to FILL on `start_load`.
  - FILL to LOADED on acceptance of beat TOTAL_BEATS-1.
  - LOADED to FILL on `start_load`.
  - `start_load` in FILL restarts the fill: the beat and row counters clear, and any beat offered that cycle is dropped.
- Reset values: state IDLE, `load_ready`=0, `buf_ready`=0, `weights`=0, `weights_valid`=0, `addr_err`=0. Memory contents are not reset.
- `load_ready` equals (state==FILL) and does not depend on `load_valid`.
- A beat is accepted when `load_valid && load_ready`. Placement of accepted beats:
  - Beat b of row r is written to bits `[LOAD_WIDTH*b +: LOAD_WIDTH]` of row r.
  - Rows fill in order from row 0; within a row, beats fill in order from beat 0 (least-significant first).
- `buf_ready` equals (state==LOADED).
- Reads are honoured only in LOADED. In IDLE and FILL, `weight_load` is ignored: `weights` holds its value and `weights_valid` stays 0.
- In LOADED, if `start_load` and `weight_load` arrive in the same cycle, `start_load` wins and the read is dropped.
- Back-to-back reads are allowed every cycle, with no bubbles.
- Address ≥ `INPUT_NODES` with no macro defined: `weights` is undefined-but-stable (memory index wraps), and `weights_valid` still pulses.

## Timing
- Read latency is 1 cycle. For `weight_load`=1 sampled at edge N in LOADED:
  - `weights` carries the addressed row from edge N+1.
  - `weights_valid` is 1 in that cycle only.
- Fill completion: the last beat is accepted at edge K. From edge K, the state is LOADED and `buf_ready`=1. A read sampled at edge K+1 returns the new data.
- `start_load` sampled at edge N:
  - `buf_ready` and `weights_valid` are 0 from edge N.
  - `load_ready` is 1 from edge N.
- `reset` sampled high at any edge forces reset values at that edge, mid-fill or mid-read. A partial fill is abandoned and `start_load` is required again.
- A full fill takes at least TOTAL_BEATS cycles (384 at defaults with `load_valid` held high).

## Configuration
- `LAYER1_WBUF_BOUNDS_CHECK_EN` defined:
  - A read with `weight_address1` ≥ `INPUT_NODES` returns an all-zero row, with `weights_valid` pulsed.
  - The same read sets `addr_err`, which stays 1 until `reset`.
- `LAYER1_WBUF_BOUNDS_CHECK_EN` undefined:
  - No range check is performed.
  - The `addr_err` port is absent.

## Structure
- Shared package `layer1_pkg` holds:
  - default widths and node counts;
  - the FSM state enum (IDLE/FILL/LOADED);
  - the BEATS_PER_ROW and TOTAL_BEATS localparams.
- One sub-module, `wbuf_row_mem`: `INPUT_NODES`×row-width storage with a beat-granular write enable and a registered full-row read port. The FSM, beat/row counters, handshake and bounds check stay in the top.

## Test plan
- Reset, then a read in IDLE → `weights`=0, `weights_valid`=0, `load_ready`=0, `buf_ready`=0.
- `start_load`, then 384 beats with beat i = {56'h0, i[7:0]} → `buf_ready` rises on the edge accepting beat 383. Read row 1 → bits [63:0] = 8'd16 zero-extended, and `weights_valid` pulses once.
- Random `load_valid` gaps (50% duty) → same row contents as the gap-free load, `load_ready` never drops in FILL, and the beat count is exactly 384.
- Reads of rows 0..23 on consecutive cycles → 24 consecutive `weights_valid` pulses with matching rows. `start_load` together with a read → no `weights_valid`, and `buf_ready`=0 next cycle.
- `reset` after beat 100 → IDLE. A fresh `start_load` plus a full load makes row 0 reflect only the new data.
- Macro defined, read address 24 → all-zero `weights`, `addr_err`=1, sticky across later valid reads until `reset`.

Source files
------------

// File: rtl/layer1_pkg.sv
// Shared constants and types for the layer1 weight buffer: default geometry,
// fill-sequencer states and the derived beat counts.
package layer1_pkg;

  localparam int L1_DATA_WIDTH   = 8;
  localparam int L1_INPUT_NODES  = 24;
  localparam int L1_OUTPUT_NODES = 128;
  localparam int L1_LOAD_WIDTH   = 64;
  localparam int L1_ADDR_WIDTH   = 5;

  localparam int L1_BEATS_PER_ROW = L1_DATA_WIDTH * L1_OUTPUT_NODES / L1_LOAD_WIDTH;
  localparam int L1_TOTAL_BEATS   = L1_INPUT_NODES * L1_BEATS_PER_ROW;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_LOADED = 2'd2
  } wbuf_state_e;

  // Counter width that stays legal when a count collapses to a single value.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wbuf_row_mem.sv
// Row-wide weight storage: beat-granular writes, registered full-row reads.
// Out-of-range read rows wrap back into the array so the output stays stable.
module wbuf_row_mem #(
  parameter int DEPTH      = 24,
  parameter int ROW_W      = 1024,
  parameter int BEAT_W     = 64,
  parameter int ADDR_W     = 5,
  parameter int BEAT_IDX_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_row,
  input  logic [BEAT_IDX_W-1:0] wr_beat,
  input  logic [BEAT_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_row,
  input  logic                  rd_zero,
  output logic [ROW_W-1:0]      rd_data
);

  localparam int BEATS = ROW_W / BEAT_W;

  logic [ROW_W-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] rd_idx_s;
  logic [ROW_W-1:0]  rd_data_q, rd_data_d;

  always_comb begin
    rd_idx_s = rd_row;
    if ({1'b0, rd_row} >= (ADDR_W + 1)'(DEPTH)) begin
      rd_idx_s = rd_row - ADDR_W'(DEPTH);
    end else begin
      rd_idx_s = rd_row;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      if (rd_zero) begin
        rd_data_d = '0;
      end else begin
        rd_data_d = mem_q[rd_idx_s];
      end
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Storage itself is never reset; only the beat slot selected by wr_beat changes.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BEATS; b++) begin
      if (wr_en && (wr_beat == BEAT_IDX_W'(b))) begin
        mem_q[wr_row][b*BEAT_W +: BEAT_W] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/layer1_weight_buffer.sv
// Weight row buffer for layer1: valid/ready beat fill, then 1-cycle row reads.
// Optional LAYER1_WBUF_BOUNDS_CHECK_EN zeroes out-of-range reads and adds sticky addr_err.
module layer1_weight_buffer
  import layer1_pkg::*;
#(
  parameter int DATA_WIDTH   = L1_DATA_WIDTH,
  parameter int INPUT_NODES  = L1_INPUT_NODES,
  parameter int OUTPUT_NODES = L1_OUTPUT_NODES,
  parameter int LOAD_WIDTH   = L1_LOAD_WIDTH,
  parameter int ADDR_WIDTH   = L1_ADDR_WIDTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start_load,
  input  logic                               load_valid,
  output logic                               load_ready,
  input  logic [LOAD_WIDTH-1:0]              load_data,
  output logic                               buf_ready,
  input  logic                               weight_load,
  input  logic [ADDR_WIDTH-1:0]              weight_address1,
  output logic [DATA_WIDTH*OUTPUT_NODES-1:0] weights,
  output logic                               weights_valid
`ifdef LAYER1_WBUF_BOUNDS_CHECK_EN
  ,
  output logic                               addr_err
`endif
);

  localparam int ROW_W  = DATA_WIDTH * OUTPUT_NODES;
  localparam int BPR    = ROW_W / LOAD_WIDTH;
  localparam int BEAT_W = idx_width(BPR);

  wbuf_state_e           state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] row_q, row_d;
  logic                  load_ready_q, load_ready_d;
  logic                  buf_ready_q, buf_ready_d;
  logic                  weights_valid_q, weights_valid_d;
  logic                  accept_s, last_beat_s, read_fire_s, oob_s;

  // A restart pulse takes priority over both a beat and a read in the same cycle.
  always_comb begin
    accept_s    = load_valid && (state_q == ST_FILL) && !start_load;
    read_fire_s = weight_load && (state_q == ST_LOADED) && !start_load;
    last_beat_s = (row_q == ADDR_WIDTH'(INPUT_NODES - 1)) && (beat_q == BEAT_W'(BPR - 1));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_load) state_d = ST_FILL;
        else            state_d = ST_IDLE;
      end
      ST_FILL: begin
        if (start_load)                   state_d = ST_FILL;
        else if (accept_s && last_beat_s) state_d = ST_LOADED;
        else                              state_d = ST_FILL;
      end
      ST_LOADED: begin
        if (start_load) state_d = ST_FILL;
        else            state_d = ST_LOADED;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    beat_d = beat_q;
    row_d  = row_q;
    if (start_load) begin
      beat_d = '0;
      row_d  = '0;
    end else if (accept_s) begin
      if (beat_q == BEAT_W'(BPR - 1)) begin
        beat_d = '0;
        if (last_beat_s) row_d = '0;
        else             row_d = row_q + ADDR_WIDTH'(1);
      end else begin
        beat_d = beat_q + BEAT_W'(1);
        row_d  = row_q;
      end
    end else begin
      beat_d = beat_q;
      row_d  = row_q;
    end
  end

  always_comb begin
    load_ready_d    = (state_d == ST_FILL);
    buf_ready_d     = (state_d == ST_LOADED);
    weights_valid_d = read_fire_s;
  end

`ifdef LAYER1_WBUF_BOUNDS_CHECK_EN
  logic addr_err_q, addr_err_d;

  always_comb begin
    oob_s      = ({1'b0, weight_address1} >= (ADDR_WIDTH + 1)'(INPUT_NODES));
    addr_err_d = addr_err_q | (read_fire_s & oob_s);
  end

  always_ff @(posedge clk) begin
    if (reset) addr_err_q <= 1'b0;
    else       addr_err_q <= addr_err_d;
  end

  assign addr_err = addr_err_q;
`else
  assign oob_s = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      beat_q          <= '0;
      row_q           <= '0;
      load_ready_q    <= 1'b0;
      buf_ready_q     <= 1'b0;
      weights_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      beat_q          <= beat_d;
      row_q           <= row_d;
      load_ready_q    <= load_ready_d;
      buf_ready_q     <= buf_ready_d;
      weights_valid_q <= weights_valid_d;
    end
  end

  wbuf_row_mem #(
    .DEPTH      (INPUT_NODES),
    .ROW_W      (ROW_W),
    .BEAT_W     (LOAD_WIDTH),
    .ADDR_W     (ADDR_WIDTH),
    .BEAT_IDX_W (BEAT_W)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept_s),
    .wr_row  (row_q),
    .wr_beat (beat_q),
    .wr_data (load_data),
    .rd_en   (read_fire_s),
    .rd_row  (weight_address1),
    .rd_zero (oob_s),
    .rd_data (weights)
  );

  assign load_ready    = load_ready_q;
  assign buf_ready     = buf_ready_q;
  assign weights_valid = weights_valid_q;

endmodule

// File: tb/tb_layer1_weight_buffer.sv
// Directed bench for layer1_weight_buffer with a row scoreboard fed at read issue.
// Build with LAYER1_WBUF_BOUNDS_CHECK_EN to exercise the zeroed out-of-range reads.
module tb_layer1_weight_buffer;

  localparam int RW    = 1024;
  localparam int NODES = 24;
  localparam int BPR   = 16;
  localparam int TOT   = 384;

  typedef struct {
    logic [RW-1:0] row;
    bit            check_data;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          start_load;
  logic          load_valid;
  logic          load_ready;
  logic [63:0]   load_data;
  logic          buf_ready;
  logic          weight_load;
  logic [4:0]    weight_address1;
  logic [RW-1:0] weights;
  logic          weights_valid;
`ifdef LAYER1_WBUF_BOUNDS_CHECK_EN
  logic          addr_err;
`endif

  exp_t          sb[$];
  exp_t          mon_e;
  logic [RW-1:0] model [NODES];
  int            n_vec;
  int            n_err;
  int            pulses;
  int            p0;

  layer1_weight_buffer dut (
    .clk             (clk),
    .reset           (reset),
    .start_load      (start_load),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .load_data       (load_data),
    .buf_ready       (buf_ready),
    .weight_load     (weight_load),
    .weight_address1 (weight_address1),
    .weights         (weights),
    .weights_valid   (weights_valid)
`ifdef LAYER1_WBUF_BOUNDS_CHECK_EN
    ,
    .addr_err        (addr_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_row(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    int lane;
    lane = 0;
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      for (int i = BPR - 1; i >= 0; i--) begin
        if (obs[64*i +: 64] !== exp[64*i +: 64]) lane = i;
      end
      $error("FAIL %s: lane %0d observed %h expected %h", tag, lane,
             obs[64*lane +: 64], exp[64*lane +: 64]);
    end
  endtask

  function automatic logic [63:0] beat_data(input logic [7:0] seed, input int i);
    logic [31:0] iv;
    iv = i;
    return {seed, 48'h0, iv[7:0]};
  endfunction

  // Issue one read in LOADED and record what must come back one cycle later.
  task automatic rd(input int addr, input bit oob);
    exp_t e;
    weight_load     = 1'b1;
    weight_address1 = 5'(addr);
    if (oob) begin
      e.row = '0;
`ifdef LAYER1_WBUF_BOUNDS_CHECK_EN
      e.check_data = 1'b1;
`else
      e.check_data = 1'b0;
`endif
    end else begin
      e.row        = model[addr];
      e.check_data = 1'b1;
    end
    sb.push_back(e);
  endtask

  // Start pulse (with a junk beat offered alongside it), then n beats.
  task automatic do_fill(input logic [7:0] seed, input int n, input bit gaps, input bit done);
    int acc;
    int drops;
    bit v;
    acc   = 0;
    drops = 0;
    start_load = 1'b1;
    load_valid = 1'b1;
    load_data  = 64'hDEAD_BEEF_0BAD_F00D;
    tick();
    start_load = 1'b0;
    chk("start_load_ready", 64'(load_ready), 64'd1);
    chk("start_buf_ready", 64'(buf_ready), 64'd0);
    while (acc < n) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      load_valid = v;
      load_data  = v ? beat_data(seed, acc) : 64'hFFFF_FFFF_FFFF_FFFF;
      if (load_ready !== 1'b1) drops++;
      if (v && acc == TOT - 1) chk("pre_last_buf_ready", 64'(buf_ready), 64'd0);
      tick();
      if (v) begin
        model[acc / BPR][64*(acc % BPR) +: 64] = beat_data(seed, acc);
        acc++;
      end
    end
    load_valid = 1'b0;
    chk("fill_ready_drops", 64'(drops), 64'd0);
    if (done) begin
      chk("done_buf_ready", 64'(buf_ready), 64'd1);
      chk("done_load_ready", 64'(load_ready), 64'd0);
    end
  endtask

  // Scoreboard side: every valid strobe must match the oldest outstanding read.
  always @(negedge clk) begin
    if (weights_valid === 1'b1) begin
      pulses++;
      n_vec++;
      assert (sb.size() > 0) else begin
        n_err++;
        $error("FAIL unexpected_valid: observed pulse expected none");
      end
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        if (mon_e.check_data) chk_row("read_row", weights, mon_e.row);
      end
    end
  end

  initial begin
    n_vec  = 0;
    n_err  = 0;
    pulses = 0;
    reset = 1'b1; start_load = 1'b0; load_valid = 1'b0; load_data = 64'h0;
    weight_load = 1'b1; weight_address1 = 5'd0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
    chk_row("idle_weights", weights, '0);
    chk("idle_valid", 64'(weights_valid), 64'd0);
    chk("idle_load_ready", 64'(load_ready), 64'd0);
    chk("idle_buf_ready", 64'(buf_ready), 64'd0);
`ifdef LAYER1_WBUF_BOUNDS_CHECK_EN
    chk("idle_addr_err", 64'(addr_err), 64'd0);
`endif
    weight_load = 1'b0;

    do_fill(8'h00, TOT, 1'b0, 1'b1);
    rd(1, 1'b0);
    tick();
    weight_load = 1'b0;
    chk("row1_beat0", weights[63:0], 64'd16);
    chk("row1_beat15", weights[1023:960], 64'd31);
    chk("row1_valid", 64'(weights_valid), 64'd1);
    tick();
    chk("row1_valid_once", 64'(weights_valid), 64'd0);

    do_fill(8'h00, TOT, 1'b1, 1'b1);
    p0 = pulses;
    for (int a = 0; a < NODES; a++) begin
      rd(a, 1'b0);
      tick();
    end
    weight_load = 1'b0;
    tick();
    chk("burst_pulses", 64'(pulses - p0), 64'd24);

    start_load = 1'b1; weight_load = 1'b1; weight_address1 = 5'd2;
    tick();
    start_load = 1'b0;
    chk("collide_valid", 64'(weights_valid), 64'd0);
    chk("collide_buf_ready", 64'(buf_ready), 64'd0);
    chk("collide_load_ready", 64'(load_ready), 64'd1);
    weight_address1 = 5'd3;
    repeat (2) tick();
    chk("fill_read_valid", 64'(weights_valid), 64'd0);
    chk_row("fill_read_hold", weights, model[23]);
    weight_load = 1'b0;

    for (int i = 0; i < 10; i++) begin
      load_valid = 1'b1;
      load_data  = beat_data(8'h77, i);
      tick();
      model[i / BPR][64*(i % BPR) +: 64] = beat_data(8'h77, i);
    end
    do_fill(8'h33, TOT, 1'b0, 1'b1);
    p0 = pulses;
    for (int a = 0; a < NODES; a++) begin
      rd(a, 1'b0);
      tick();
    end
    rd(24, 1'b1);
    tick();
    rd(5, 1'b0);
    tick();
    weight_load = 1'b0;
    tick();
    chk("oob_pulses", 64'(pulses - p0), 64'd26);
`ifdef LAYER1_WBUF_BOUNDS_CHECK_EN
    chk("addr_err_sticky", 64'(addr_err), 64'd1);
`endif

    do_fill(8'h5A, 101, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_load_ready", 64'(load_ready), 64'd0);
    chk("rst_buf_ready", 64'(buf_ready), 64'd0);
    chk("rst_valid", 64'(weights_valid), 64'd0);
    chk_row("rst_weights", weights, '0);
`ifdef LAYER1_WBUF_BOUNDS_CHECK_EN
    chk("rst_addr_err", 64'(addr_err), 64'd0);
`endif
    load_valid = 1'b1;
    repeat (2) tick();
    chk("post_rst_load_ready", 64'(load_ready), 64'd0);
    chk("post_rst_buf_ready", 64'(buf_ready), 64'd0);
    load_valid = 1'b0;

    do_fill(8'hC3, TOT, 1'b0, 1'b1);
    rd(0, 1'b0);
    tick();
    chk("row0_new", weights[63:0], {8'hC3, 48'h0, 8'h00});
    rd(23, 1'b0);
    tick();
    rd(12, 1'b0);
    tick();
    weight_load = 1'b0;
    repeat (2) tick();
    chk("sb_drain", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
